// File: rtl/design_28_pkg.sv
// Shared types and helpers for the design_28 round-robin core scheduler.
package design_28_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CNT_W = 4;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/design_28_sched_if.sv
// Requester/response handshake bundle between requester subsystems and the scheduler.
interface design_28_sched_if
  import design_28_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREQ = 4
);
  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [W-1:0]            rsp_y;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/design_28_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module design_28_rr_arb
  import design_28_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);
  logic            found;
  logic [ID_W-1:0] sel;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % NREQ);
      if (en && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        idx      = sel;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/design_28_sched.sv
// Shares one design_28_core between NREQ requesters: round-robin accept,
// hold operands for CORE_LAT cycles, then return the result tagged with its requester.
module design_28_sched
  import design_28_pkg::*;
#(
  parameter int W        = 16,
  parameter int NREQ     = 4,
  parameter int CORE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  design_28_sched_if.slave   bus,
  output logic [W-1:0]       core_a,
  output logic [W-1:0]       core_b,
  input  logic [W-1:0]       core_y,
  output logic               busy
);
  localparam int ID_W = id_w(NREQ);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gidx;
  logic             accept;

  // Arbiter only enabled in IDLE, so req_ready is zero for the whole transaction.
  design_28_rr_arb #(.NREQ(NREQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (state == IDLE),
    .gnt (gnt),
    .idx (gidx)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      id_q          <= '0;
      cnt           <= '0;
      core_a        <= '0;
      core_b        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          core_a <= bus.req_a[gidx];
          core_b <= bus.req_b[gidx];
          id_q   <= gidx;
          cnt    <= CNT_W'(CORE_LAT - 1);
          ptr    <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
        WAIT: if (cnt == '0) begin
          bus.rsp_y     <= core_y;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/design_28_sched.md
Name: design_28_sched

Overview:
- Round-robin scheduler that shares one design_28_core instance between NREQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake and drives registered operands into the core.
- Waits CORE_LAT cycles, then captures the core result and returns it with the requester ID over a valid/ready response channel.
- Sits between the requester subsystems and the core; replaces per-requester operand registers and the start/valid control.

Parameters:
- W, 16, operand/result width.
- NREQ, 4, number of requesters (2..8).
- CORE_LAT, 1, cycles from core operand update to stable core_y (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  NREQ  bit i: requester i presents operands.
- req_ready  out  NREQ  bit i: requester i accepted this cycle.
- req_a  in  NREQ*W  operand a, requester i at [i*W +: W].
- req_b  in  NREQ*W  operand b, same packing.
- core_a  out  W  registered operand a to core.
- core_b  out  W  registered operand b to core.
- core_y  in  W  core result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(NREQ)  requester index of the result.
- rsp_y  out  W  result.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: state IDLE; core_a, core_b, rsp_y, rsp_id, wait counter = 0; rsp_valid = 0; busy = 0; rr pointer = 0, so requester 0 has top priority after reset.
- req_ready is combinational: one-hot, only in IDLE, only on the granted index. All zero outside IDLE or when no req_valid is set. It may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Grant is round-robin: search order starts at ptr and wraps modulo NREQ. On accept of index g, ptr <= (g+1) mod NREQ. ptr is unchanged when nothing is accepted.
- FSM:
  - IDLE: if any req_valid, then accept g; core_a <= req_a[g]; core_b <= req_b[g]; id_q <= g; cnt <= CORE_LAT-1; go to WAIT.
  - WAIT: if cnt == 0, then rsp_y <= core_y; rsp_id <= id_q; rsp_valid <= 1; go to RESP. Otherwise cnt <= cnt-1.
  - RESP: hold rsp_valid, rsp_y and rsp_id stable until rsp_ready. On rsp_valid && rsp_ready, rsp_valid <= 0 and go to IDLE.
- core_a and core_b hold their value outside IDLE accepts, so the core input stays stable for the whole transaction.
- Latency: accept in cycle T, rsp_valid high in cycle T+CORE_LAT+1. Minimum spacing between accepts is CORE_LAT+2 cycles (no same-cycle RESP->accept).
- rsp_valid is never deasserted without rsp_ready. Backpressure of any length is legal.
- req_valid changes while not granted: no effect. A requester that drops valid before grant is simply skipped.
- All requesters valid continuously: grants rotate 0,1,2,3,0,...
- Reset mid-operation: the in-flight transaction is discarded, all outputs return to reset values, and no response is issued.
- Widths: no arithmetic on data; cnt is 4 bits; ID is $clog2(NREQ) bits.

Decomposition:
- Package design_28_pkg holds:
  - FSM state enum {IDLE, WAIT, RESP};
  - function id_w(NREQ) = $clog2(NREQ);
  - localparam CNT_W = 4.
- Natural sub-module: design_28_rr_arb (NREQ). Inputs: req vector, ptr, enable. Outputs: one-hot grant and encoded index. It is purely combinational; ptr lives in the scheduler.
- Bench uses a core stub with y = (a + b) mod 2^W, registered CORE_LAT-1 times.

Test Plan:
- Single request, CORE_LAT=1: requester 2 sends a=0x0005, b=0x0003 at T. Expect req_ready[2] at T, rsp_valid at T+2 with rsp_id=2 and rsp_y=0x0008.
- All four req_valid held high, rsp_ready=1: grant order 0,1,2,3,0. Accepts are 3 cycles apart; rsp_id follows the same sequence.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. rsp_y/rsp_id stay stable, req_ready stays 0, and busy=1. Release rsp_ready; one cycle later the state is IDLE.
- Wrap-around: a=0xFFFF, b=0x0002 from requester 3, then requester 0 valid. Expect rsp_y=0x0001 with id 3, followed by the requester 0 grant.
- CORE_LAT=4: accept at T; rsp_valid first high at T+5. core_a/core_b are unchanged T+1..T+5.
- Reset asserted in WAIT: rsp_valid stays 0, all outputs go to 0 asynchronously, and the next grant after release goes to requester 0.
